// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } dmem_state_e;

    localparam logic [2:0] DMEM_SZ_BYTE = 3'b001;
    localparam logic [2:0] DMEM_SZ_HALF = 3'b010;
    localparam logic [2:0] DMEM_SZ_WORD = 3'b100;

    localparam int DMEM_SIGN_BIT = 3;

endpackage

// File: rtl/dmem_lane_align.sv
// Load lane extract/extend and store lane merge.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  byte_off,
    input  logic [2:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic        is_byte;
    logic        is_half;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign is_byte = (size == DMEM_SZ_BYTE);
    assign is_half = (size == DMEM_SZ_HALF);
    assign lane_h  = byte_off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        lane_b = rdata[7:0];
        unique case (byte_off)
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            2'd3: lane_b = rdata[31:24];
        endcase
    end

    always_comb begin
        load_data  = rdata;
        store_data = wdata;
        unique case (1'b1)
            is_byte: begin
                load_data  = {{24{sign_ext & lane_b[7]}}, lane_b};
                store_data = rdata;
                unique case (byte_off)
                    2'd0: store_data[7:0]   = wdata[7:0];
                    2'd1: store_data[15:8]  = wdata[7:0];
                    2'd2: store_data[23:16] = wdata[7:0];
                    2'd3: store_data[31:24] = wdata[7:0];
                endcase
            end
            is_half: begin
                load_data  = {{16{sign_ext & lane_h[15]}}, lane_h};
                store_data = rdata;
                if (byte_off[1]) store_data[31:16] = wdata[15:0];
                else             store_data[15:0]  = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: loads, RMW sub-word stores, stall.
// DMEM_WORD_STORE_BYPASS_EN: aligned word stores write in IDLE, no stall.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int WORD_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    input  logic                       req_memwrite,
    input  logic                       req_memread,
    input  logic [3:0]                 req_sign_mask,
    output logic [31:0]                rd_data,
    output logic                       stall,
    output logic                       err_misaligned,
    output logic [WORD_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]                mem_wdata,
    output logic                       mem_we,
    input  logic [31:0]                mem_rdata
);

    dmem_state_e state;

    logic [2:0]  size;
    logic        is_byte, is_half, is_word;
    logic        req_any, req_err;
    logic        req_load, req_sstore, req_wstore;
    logic        bypass_hit;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data, store_data;
    logic        unused_addr;

    assign size    = req_sign_mask[2:0];
    assign is_byte = (size == DMEM_SZ_BYTE);
    assign is_half = (size == DMEM_SZ_HALF);
    assign is_word = (size == DMEM_SZ_WORD);
    assign req_any = req_memread | req_memwrite;

    // Both strobes or a non-one-hot size fold into the misaligned path.
    assign req_err = req_any & ((req_memread & req_memwrite)
                   | ~(is_byte | is_half | is_word)
                   | (is_half & req_addr[0])
                   | (is_word & (|req_addr[1:0])));

    assign req_load   = req_memread & ~req_err;
    assign req_sstore = req_memwrite & ~req_err & ~is_word;
    assign req_wstore = req_memwrite & ~req_err & is_word;

`ifdef DMEM_WORD_STORE_BYPASS_EN
    assign bypass_hit = rst_n & (state == ST_IDLE) & req_wstore;
`else
    assign bypass_hit = 1'b0;
`endif

    assign mem_addr    = req_addr[WORD_ADDR_WIDTH+1:2];
    assign unused_addr = ^{req_addr[31:WORD_ADDR_WIDTH+2]};

    assign stall = rst_n & (((state == ST_IDLE) & req_any & ~bypass_hit)
                 | (state == ST_READ) | (state == ST_WRITE));

    assign mem_we    = we_q | bypass_hit;
    assign mem_wdata = bypass_hit ? req_wdata : wdata_q;

    dmem_lane_align u_align (
        .byte_off   (req_addr[1:0]),
        .size       (size),
        .sign_ext   (req_sign_mask[DMEM_SIGN_BIT]),
        .rdata      (mem_rdata),
        .wdata      (req_wdata),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            rd_data        <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            err_misaligned <= 1'b0;
        end else begin
            we_q           <= 1'b0;
            err_misaligned <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    unique case (1'b1)
                        req_err: begin
                            rd_data        <= '0;
                            err_misaligned <= 1'b1;
                            state          <= ST_DONE;
                        end
                        req_load, req_sstore: state <= ST_READ;
                        req_wstore: begin
`ifndef DMEM_WORD_STORE_BYPASS_EN
                            we_q    <= 1'b1;
                            wdata_q <= req_wdata;
                            state   <= ST_WRITE;
`endif
                        end
                        default: ;
                    endcase
                end
                ST_READ: begin
                    if (req_memwrite) begin
                        we_q    <= 1'b1;
                        wdata_q <= store_data;
                        state   <= ST_WRITE;
                    end else begin
                        rd_data <= load_data;
                        state   <= ST_DONE;
                    end
                end
                ST_WRITE: state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Data-memory access controller between the processor's data-memory port and the single-port block RAM. Performs aligned word, halfword and byte loads with sign/zero extension, and byte/halfword stores by read-modify-write. Drives the `stall` signal that holds the processor clock high while a multi-cycle access is in progress.

## Interface
- `WORD_ADDR_WIDTH`, default 10: word-address bits into the RAM (1024 × 32-bit).
- `clk` in 1: single clock. RAM and controller use it; the processor gets the gated copy.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_addr` in 32: byte address from the processor.
- `req_wdata` in 32: store data, right-aligned.
- `req_memwrite` in 1: store request level, held by the processor while stalled.
- `req_memread` in 1: load request level, held while stalled.
- `req_sign_mask` in 4:
  - bit3 = sign-extend the load (1 = signed).
  - bits[2:0] = access size, one-hot: `001` byte, `010` half, `100` word.
- `rd_data` out 32: aligned, extended load result.
- `stall` out 1: high while an access is incomplete.
- `err_misaligned` out 1: one-cycle pulse on a misaligned or illegal request.
- `mem_addr` out WORD_ADDR_WIDTH: RAM word address, which is `req_addr[WORD_ADDR_WIDTH+1:2]`.
- `mem_wdata` out 32: RAM write data.
- `mem_we` out 1: RAM write enable.
- `mem_rdata` in 32: RAM read data, valid the cycle after the address is presented.

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE, no request:**
  - `stall`=0.
  - `mem_addr` follows `req_addr`.
- **IDLE + load:**
  - `stall`=1 combinationally.
  - Go to READ.
- **READ:**
  - Register `mem_rdata`.
  - For a load: extract the lane selected by `req_addr[1:0]`, extend per bit3, write `rd_data`, go to DONE.
  - For a sub-word store: go to WRITE.
- **IDLE + sub-word store:** `stall`=1, go to READ.
- **IDLE + word store:** `stall`=1, go to WRITE.
- **WRITE:**
  - `mem_we`=1.
  - `mem_wdata` is either the full `req_wdata`, or the registered read word with the target byte/half lanes replaced by `req_wdata[7:0]` / `req_wdata[15:0]`.
  - Go to DONE.
- **DONE:**
  - `stall`=0, so the processor advances on this edge.
  - Go to IDLE. Requests seen in IDLE after DONE are treated as new.
- **Misaligned requests** (half with `addr[0]`=1, word with `addr[1:0]`≠0):
  - No RAM write.
  - `rd_data`=0.
  - `err_misaligned` pulses.
  - IDLE→DONE.
- **Illegal requests** (`req_memread` and `req_memwrite` both high, or size not one-hot): treated as misaligned.
- **`rst_n` low at any time:**
  - State becomes IDLE.
  - `rd_data`, `stall`, `mem_we`, `err_misaligned` = 0.
  - `mem_wdata` = 0.
  - An in-flight store is abandoned and no partial write occurs.

## Timing
- Load: `stall` high for 2 cycles (IDLE, READ). `rd_data` is valid from the DONE cycle until the next load completes.
- Sub-word store: `stall` high for 3 cycles (IDLE, READ, WRITE). The RAM is written at the end of WRITE.
- Word store: `stall` high for 2 cycles (IDLE, WRITE).
- `stall` is asserted combinationally in IDLE, within the low phase before the processor's next edge. It is deasserted registered, on entry to DONE.
- `mem_we` is registered, high for exactly one cycle per store.
- All outputs other than `stall` and `mem_addr` are registered.

## Configuration
- `DMEM_WORD_STORE_BYPASS_EN` defined:
  - An aligned word store in IDLE drives `mem_we`=1 and `mem_wdata`=`req_wdata` combinationally.
  - `stall` stays 0 and the state stays IDLE, so a word store takes 0 stall cycles.
- Undefined: word stores take the IDLE→WRITE→DONE path above.
- Loads and sub-word stores are identical in both builds.

## Structure
- Package `dmem_pkg` holds:
  - the state enum;
  - the size encodings `DMEM_SZ_BYTE`/`DMEM_SZ_HALF`/`DMEM_SZ_WORD`;
  - the sign bit index `DMEM_SIGN_BIT`=3.
- Sub-module `dmem_lane_align` (combinational) holds the load lane extract/extend and the store lane merge. The FSM and registers live in `dmem_access_ctrl`.

## Test plan
- Word store 0xDEADBEEF @0x10, then signed word load @0x10:
  - `rd_data`=0xDEADBEEF.
  - Store stall 2 cycles (0 with bypass), load stall 2 cycles.
- Byte store 0xAB @0x13 over 0x11223344:
  - RAM word becomes 0xAB223344.
  - Signed byte load @0x13 → 0xFFFFFFAB; unsigned → 0x000000AB.
- Half store 0x8001 @0x12 over 0:
  - RAM word becomes 0x80010000.
  - Signed half load → 0xFFFF8001; unsigned → 0x00008001.
- Half load @0x11:
  - `err_misaligned` pulses once.
  - `rd_data`=0, no `mem_we`, stall 1 cycle.
- `rst_n` low during the READ state of a byte store:
  - No `mem_we` ever.
  - Outputs 0, state IDLE.
  - RAM contents unchanged.
- Back-to-back load then store with requests held across DONE: exactly one access each, and no duplicate write.
